// File: rtl/echo_request_input.sv
// echo_request_input: inbound demarshaller for the echo portal.
// Buffers 96-bit pipe messages in a 2-entry ping-pong store and dispatches them as say/say2 calls.
module echo_request_input #(
    parameter logic [31:0] TAG_SAY  = 32'd1,
    parameter logic [31:0] TAG_SAY2 = 32'd2,
    parameter int          ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pipe_enq_ena,
    input  logic [95:0]      pipe_enq_v,
    output logic             pipe_enq_rdy,
    output logic             request_say_ena,
    output logic [31:0]      request_say_meth,
    output logic [31:0]      request_say_v,
    input  logic             request_say_rdy,
    output logic             request_say2_ena,
    output logic [31:0]      request_say2_a,
    output logic [31:0]      request_say2_b,
    input  logic             request_say2_rdy,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      err_tag
);
    logic [31:0] tag_q [2];
    logic [31:0] w0_q [2];
    logic [31:0] w1_q [2];
    logic [1:0]  vld;
    logic        wr_sel, rd_sel;
    logic        h_vld, is_say, is_say2, drop, pop, enq;
    logic [31:0] h_tag;

    always_comb begin
        h_vld = vld[rd_sel];
        h_tag = tag_q[rd_sel];
        is_say = h_tag == TAG_SAY;
        is_say2 = h_tag == TAG_SAY2;
        pipe_enq_rdy = !(vld[0] & vld[1]);
        enq = pipe_enq_ena & pipe_enq_rdy;
        request_say_ena = h_vld & is_say & request_say_rdy;
        request_say2_ena = h_vld & is_say2 & request_say2_rdy;
        request_say_meth = w0_q[rd_sel];
        request_say_v = w1_q[rd_sel];
        request_say2_a = w0_q[rd_sel];
        request_say2_b = w1_q[rd_sel];
        // unknown tags leave the head immediately, regardless of downstream readiness
        drop = h_vld & !is_say & !is_say2;
        pop = request_say_ena | request_say2_ena | drop;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            vld <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            err_count <= '0;
            err_tag <= '0;
            for (int i = 0; i < 2; i++) begin
                tag_q[i] <= '0;
                w0_q[i] <= '0;
                w1_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld[rd_sel] <= 1'b0;
                rd_sel <= ~rd_sel;
            end
            // enqueue never targets the head being popped: it needs a free slot
            if (enq) begin
                vld[wr_sel] <= 1'b1;
                tag_q[wr_sel] <= pipe_enq_v[31:0];
                w0_q[wr_sel] <= pipe_enq_v[63:32];
                w1_q[wr_sel] <= pipe_enq_v[95:64];
                wr_sel <= ~wr_sel;
            end
            if (drop) begin
                err_tag <= h_tag;
                if (~&err_count)
                    err_count <= err_count + ERR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_echo_request_input.sv
// tb_echo_request_input: scoreboard bench; the driver queues expected calls, a negedge monitor pops and compares.
module tb_echo_request_input;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_enq_ena = 1'b0;
    logic [95:0] pipe_enq_v = '0;
    logic        pipe_enq_rdy, pipe_enq_rdy_s;
    logic        request_say_ena, request_say_ena_s;
    logic [31:0] request_say_meth, request_say_meth_s, request_say_v, request_say_v_s;
    logic        request_say_rdy = 1'b1;
    logic        request_say2_ena, request_say2_ena_s;
    logic [31:0] request_say2_a, request_say2_a_s, request_say2_b, request_say2_b_s;
    logic        request_say2_rdy = 1'b1;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    logic [31:0] err_tag, err_tag_s;

    echo_request_input dut (
        .CLK(CLK), .nRST(nRST), .pipe_enq_ena(pipe_enq_ena), .pipe_enq_v(pipe_enq_v),
        .pipe_enq_rdy(pipe_enq_rdy), .request_say_ena(request_say_ena),
        .request_say_meth(request_say_meth), .request_say_v(request_say_v),
        .request_say_rdy(request_say_rdy), .request_say2_ena(request_say2_ena),
        .request_say2_a(request_say2_a), .request_say2_b(request_say2_b),
        .request_say2_rdy(request_say2_rdy), .err_count(err_count), .err_tag(err_tag)
    );

    echo_request_input #(.ERR_W(2)) dut_sat (
        .CLK(CLK), .nRST(nRST), .pipe_enq_ena(pipe_enq_ena), .pipe_enq_v(pipe_enq_v),
        .pipe_enq_rdy(pipe_enq_rdy_s), .request_say_ena(request_say_ena_s),
        .request_say_meth(request_say_meth_s), .request_say_v(request_say_v_s),
        .request_say_rdy(request_say_rdy), .request_say2_ena(request_say2_ena_s),
        .request_say2_a(request_say2_a_s), .request_say2_b(request_say2_b_s),
        .request_say2_rdy(request_say2_rdy), .err_count(err_count_s), .err_tag(err_tag_s)
    );

    always #5 CLK = ~CLK;

    logic [95:0] sb[$];
    int          disp_log[$];
    int          n_vec = 0, n_err = 0, cyc = 0, exp_drops = 0;
    logic [31:0] last_bad = '0;
    logic        rnd_on = 1'b0;
    int          d0, d1;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // monitor: every presented call must match the oldest outstanding expected call
    always @(negedge CLK) begin
        if (nRST && (request_say_ena || request_say2_ena)) begin
            chk("one_ena", {request_say_ena, request_say2_ena} == 2'b11, 0);
            chk("ena_needs_rdy", request_say_ena ? request_say_rdy : request_say2_rdy, 1);
            disp_log.push_back(cyc);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_call: got say=%0b say2=%0b expected none", request_say_ena, request_say2_ena);
            end else
                chk("call", {request_say_ena ? 32'd1 : 32'd2,
                             request_say_ena ? request_say_meth : request_say2_a,
                             request_say_ena ? request_say_v : request_say2_b}, sb.pop_front());
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rnd_on) begin
            request_say_rdy = $urandom_range(0, 3) != 0;
            request_say2_rdy = $urandom_range(0, 3) != 0;
        end
    end

    // offers one message, waits for acceptance, and records what the consumer should see
    task automatic send(input logic [31:0] t, input logic [31:0] a, input logic [31:0] b,
                        output int waits, output int acc);
        waits = 0;
        if (!CLK) begin
            @(posedge CLK);
            #1;
        end
        pipe_enq_ena = 1'b1;
        pipe_enq_v = {b, a, t};
        @(negedge CLK);
        while (!pipe_enq_rdy && waits < 50) begin
            @(negedge CLK);
            waits++;
        end
        acc = cyc + 1;
        if (!pipe_enq_rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got rdy=0 expected rdy=1 within 50 cycles");
        end else if (t == 32'd1 || t == 32'd2)
            sb.push_back({t, a, b});
        else begin
            exp_drops++;
            last_bad = t;
        end
        @(posedge CLK);
        #1;
        pipe_enq_ena = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 nRST = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        sb.delete();
        exp_drops = 0;
        last_bad = '0;
    endtask

    task automatic drain();
        int n = 0;
        request_say_rdy = 1'b1;
        request_say2_rdy = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic chk_err();
        chk("err_count", err_count, exp_drops > 65535 ? 65535 : exp_drops);
        chk("err_tag", err_tag, last_bad);
        chk("err_count_sat", err_count_s, exp_drops > 3 ? 3 : exp_drops);
    endtask

    initial begin
        int n0, n1, n2, t0;
        do_reset();
        @(negedge CLK);
        chk("rst_rdy", pipe_enq_rdy, 1);
        chk("rst_ena", {request_say_ena, request_say2_ena}, 0);
        chk("rst_data", {request_say_meth, request_say_v, request_say2_a, request_say2_b}, 0);
        chk("rst_err", {err_count, err_tag}, 0);

        disp_log.delete();
        send(32'd1, 32'd7, 32'd5, n0, t0);
        @(negedge CLK);
        chk("single_say_ena", {request_say_ena, request_say2_ena, pipe_enq_rdy}, 3'b101);
        @(negedge CLK);
        chk("single_after", request_say_ena, 0);
        chk("single_latency", disp_log.size() > 0 ? disp_log[0] : -1, t0);

        disp_log.delete();
        send(32'd1, 32'hA, 32'hB, n0, t0);
        send(32'd2, 32'hC, 32'hD, n1, d1);
        send(32'd1, 32'hE, 32'hF, n2, d1);
        chk("b2b_no_stall", n0 + n1 + n2, 0);
        repeat (3) @(negedge CLK);
        chk("b2b_count", disp_log.size(), 3);
        if (disp_log.size() == 3)
            chk("b2b_cycles", {disp_log[0], disp_log[1], disp_log[2]}, {t0, t0 + 1, t0 + 2});

        request_say_rdy = 1'b0;
        send(32'd1, 32'h11, 32'h12, n0, d1);
        send(32'd1, 32'h21, 32'h22, n1, d1);
        fork
            send(32'd1, 32'h31, 32'h32, d0, d1);
        join_none
        @(negedge CLK);
        chk("bp_full", pipe_enq_rdy, 0);
        @(negedge CLK);
        chk("bp_hold", {pipe_enq_rdy, request_say_ena}, 0);
        @(posedge CLK);
        #1 request_say_rdy = 1'b1;
        @(negedge CLK);
        chk("bp_release", {request_say_ena, pipe_enq_rdy}, 2'b10);
        @(negedge CLK);
        chk("bp_rdy_return", pipe_enq_rdy, 1);
        wait fork;
        drain();

        request_say_rdy = 1'b0;
        send(32'h55, 32'd9, 32'd9, n0, d1);
        send(32'd1, 32'd1, 32'd2, n1, d1);
        repeat (3) @(negedge CLK);
        chk("unk_no_stall", {pipe_enq_rdy, request_say_ena}, 2'b10);
        chk_err();
        drain();

        for (int i = 0; i < 5; i++) send(32'h70 + i, i, i, n0, d1);
        repeat (3) @(negedge CLK);
        chk_err();

        request_say_rdy = 1'b0;
        send(32'd1, 32'h41, 32'h42, n0, d1);
        send(32'd1, 32'h51, 32'h52, n1, d1);
        @(negedge CLK);
        chk("pre_reset_full", pipe_enq_rdy, 0);
        do_reset();
        request_say_rdy = 1'b1;
        request_say2_rdy = 1'b1;
        @(negedge CLK);
        chk("mid_reset", {pipe_enq_rdy, request_say_ena, request_say2_ena, err_count}, {3'b100, 16'd0});
        repeat (5) @(negedge CLK);
        chk("mid_reset_quiet", {request_say_ena, request_say2_ena}, 0);

        rnd_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 4);
            logic [31:0] t = r < 2 ? 32'd1 : r < 4 ? 32'd2 : 32'h100 + $urandom_range(0, 255);
            send(t, $urandom, $urandom, n0, d1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        rnd_on = 1'b0;
        @(posedge CLK);
        #2;
        drain();
        chk_err();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1);
    end
endmodule

// File: doc/echo_request_input.md
Name: echo_request_input

Overview:
- Inbound demarshaller for the echo portal.
- Accepts 96-bit messages on a pipe enq interface, buffers them in a 2-entry ping-pong store and decodes the tag word.
- Dispatches each message as one method call: say(meth, v) or say2(a, b).
- Messages with unknown tags are dropped and counted.
- Sits between the transport pipe and the request-side user logic.

Parameters:
- TAG_SAY, 1, tag value that selects the say method.
- TAG_SAY2, 2, tag value that selects the say2 method.
- ERR_W, 16, width of the dropped-message counter.

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous active-low reset
- pipe_enq_ena  input  1  pipe delivers a message this cycle (valid only when pipe_enq_rdy=1)
- pipe_enq_v  input  96  message: [31:0] tag, [63:32] word0, [95:64] word1
- pipe_enq_rdy  output  1  buffer can accept a message
- request_say_ena  output  1  invoke say this cycle
- request_say_meth  output  32  say argument meth (word0 of head entry)
- request_say_v  output  32  say argument v (word1 of head entry)
- request_say_rdy  input  1  downstream can accept say
- request_say2_ena  output  1  invoke say2 this cycle
- request_say2_a  output  32  say2 argument a (word0 of head entry)
- request_say2_b  output  32  say2 argument b (word1 of head entry)
- request_say2_rdy  input  1  downstream can accept say2
- err_count  output  ERR_W  number of dropped unknown-tag messages; saturating
- err_tag  output  32  tag of the most recently dropped message

Behaviour:
- Reset: clock CLK; reset nRST, synchronous, active-low.
  - While nRST=0 at a CLK edge: both entries are invalidated, wr_sel=0, rd_sel=0, err_count=0, err_tag=0.
  - Stored tag and data registers are cleared to 0.
  - Messages in flight at reset are lost.
  - After reset: pipe_enq_rdy=1; both ena outputs are 0 and all data outputs are 0.
- Storage: two entries, each holding tag, word0, word1 and a valid bit.
  - wr_sel selects the entry to write; rd_sel selects the head entry.
  - Each select toggles after its own operation. Order is FIFO.
- Enqueue: pipe_enq_rdy = !(valid0 & valid1).
  - An enqueue fires when pipe_enq_ena & pipe_enq_rdy.
  - It writes entry[wr_sel], sets that entry's valid bit and toggles wr_sel.
  - When the buffer is full, pipe_enq_rdy=0; there is no same-cycle bypass from a departing head.
- Dispatch is combinational from the head entry H = entry[rd_sel]:
  - request_say_ena = H.valid & (H.tag==TAG_SAY) & request_say_rdy.
  - request_say2_ena = H.valid & (H.tag==TAG_SAY2) & request_say2_rdy.
  - Argument outputs always show H.word0/H.word1, whatever the valid bit.
  - At most one ena is high per cycle.
- Pop: at the clock edge, the head is cleared and rd_sel toggles when either ena is high, or when H.valid and H.tag matches neither TAG_SAY nor TAG_SAY2.
  - An unknown tag is dropped in one cycle, independent of the rdy inputs.
- Drop accounting: on each drop, err_tag <= H.tag and err_count increments.
  - err_count saturates at 2^ERR_W-1 and never wraps.
- Latency: a message enqueued at edge N is first presented at edge N+1 (visible on ena during cycle N+1).
  - Sustained throughput is 1 message/cycle while the downstream rdy stays high. The 2 entries cover the edge-to-dispatch gap.
- Simultaneous enqueue and pop in one cycle, buffer not full:
  - Both take effect.
  - Occupancy is unchanged.
  - The entries are distinct because of the wr_sel/rd_sel ordering.
- Backpressure: a head stalled by low rdy holds its ena low and its outputs stable. The buffer fills, then pipe_enq_rdy drops.
- Tag compare is on the full 32 bits. TAG_SAY must not equal TAG_SAY2.

Test Plan:
- Reset then single say: enqueue {word1=0x0000_0005, word0=0x0000_0007, tag=1} with request_say_rdy=1 → request_say_ena=1 exactly one cycle later with meth=7, v=5; request_say2_ena stays 0; pipe_enq_rdy stays 1.
- Back-to-back mixed: enqueue tag1 (A,B), tag2 (C,D), tag1 (E,F) on consecutive cycles with both rdy inputs=1 → say(A,B), say2(C,D), say(E,F) on three consecutive cycles; pipe_enq_rdy never falls.
- Backpressure: request_say_rdy=0 and enqueue 3 tag1 messages → pipe_enq_rdy=0 after the second is accepted and the third is held by the sender. Raise rdy → all three are delivered in order; pipe_enq_rdy returns to 1 the cycle after the first pop.
- Unknown tag: enqueue tag=0x55 then tag1 (1,2) with request_say_rdy=0 → 0x55 dropped without stalling; err_count=1, err_tag=0x55; say(1,2) is held until rdy is raised.
- Counter saturation with ERR_W=2 → after 5 unknown-tag messages err_count=3.
- Reset mid-operation: buffer full and stalled, assert nRST=0 for one cycle → both entries are invalid, pipe_enq_rdy=1, no ena is asserted afterwards, and err_count=0.
